// File: rtl/exmuldiv.sv
// exmuldiv: iterative RV32M/RV64M multiply/divide unit sitting beside the execute stage.
// Latency: accept at T, valid_o at T+XLEN+1; div-by-zero/overflow (and multiplies with MULDIV_FAST_MUL_EN) at T+1.
// Backpressure: none on the write-back beat; hold_o stalls the PC from the issue cycle until the result cycle.
module exmuldiv #(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic [2:0]         op_i,
   input  logic [XLEN-1:0]    rs1_rdata,
   input  logic [XLEN-1:0]    rs2_rdata,
   input  logic [RADDR_W-1:0] rd_waddr,
   input  logic               flush_i,
   output logic               hold_o,
   output logic               valid_o,
   output logic [RADDR_W-1:0] rd_waddr_o,
   output logic [XLEN-1:0]    rd_wdata_o
);

   localparam int               CNT_W    = $clog2(XLEN) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
   localparam logic [XLEN-1:0]  XMIN     = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state;
   logic [2:0]          op_q;
   logic [RADDR_W-1:0]  rd_q;
   logic [XLEN-1:0]     opnd;   // multiplicand magnitude, or divisor magnitude
   logic [2*XLEN-1:0]   acc;    // mul: {partial sum, multiplier}; div: {remainder, dividend/quotient}
   logic                neg;    // result needs two's complement negation in DONE
   logic [CNT_W-1:0]    cnt;

   logic                is_div;
   logic                s1_signed;
   logic                s2_signed;
   logic                sgn1;
   logic                sgn2;
   logic                neg_res;
   logic                div_zero;
   logic                div_ovf;
   logic [XLEN-1:0]     mag1;
   logic [XLEN-1:0]     mag2;

   // Decode the op offered this cycle: operand signedness, magnitudes, result sign, special cases
   always_comb begin
      is_div    = op_i[2];
      // MULHSU treats rs2 as unsigned; MUL low bits are sign-independent so it runs unsigned
      s1_signed = is_div ? ~op_i[0] : ((op_i[1:0] == 2'b01) || (op_i[1:0] == 2'b10));
      s2_signed = is_div ? ~op_i[0] : (op_i[1:0] == 2'b01);
      sgn1      = s1_signed & rs1_rdata[XLEN-1];
      sgn2      = s2_signed & rs2_rdata[XLEN-1];
      mag1      = sgn1 ? -rs1_rdata : rs1_rdata;
      mag2      = sgn2 ? -rs2_rdata : rs2_rdata;
      // Remainder follows the dividend sign; quotient and product follow sign1^sign2
      neg_res   = (is_div && op_i[1]) ? sgn1 : (sgn1 ^ sgn2);
      div_zero  = is_div && (rs2_rdata == '0);
      div_ovf   = is_div && !op_i[0] && (rs1_rdata == XMIN) && (rs2_rdata == '1);
   end

   logic [XLEN:0]       mul_sum;
   logic [2*XLEN-1:0]   mul_next;
   logic [XLEN:0]       div_shift;
   logic [XLEN:0]       div_diff;
   logic                div_ge;
   logic [2*XLEN-1:0]   div_next;

   // One iteration of shift-add multiply and restoring shift-subtract divide
   always_comb begin
      mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
      mul_next  = {mul_sum, acc[XLEN-1:1]};
      div_shift = acc[2*XLEN-1:XLEN-1];
      div_diff  = div_shift - {1'b0, opnd};
      div_ge    = (div_shift >= {1'b0, opnd});
      div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc[XLEN-2:0], div_ge};
   end

   logic [2*XLEN-1:0]   prod;
   logic [XLEN-1:0]     div_half;
   logic [XLEN-1:0]     div_res;
   logic [XLEN-1:0]     result;

   // Sign-correct the latched magnitude and pick the requested half
   always_comb begin
      prod     = neg ? -acc : acc;
      div_half = op_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
      div_res  = neg ? -div_half : div_half;
      if (op_q[2]) begin
         result = div_res;
      end else if (op_q[1:0] == 2'b00) begin
         result = prod[XLEN-1:0];
      end else begin
         result = prod[2*XLEN-1:XLEN];
      end
   end

   // Write-back beat: only in DONE, and a same-cycle flush cancels it
   always_comb begin
      valid_o    = (state == DONE) && !flush_i;
      rd_waddr_o = valid_o ? rd_q : '0;
      rd_wdata_o = valid_o ? result : '0;
   end

   // PC stall: issue cycle (so the PC holds before the FSM moves) plus every CALC cycle
   always_comb begin
      hold_o = (((state == IDLE) || (state == DONE)) && start_i && !flush_i) || (state == CALC);
   end

   // Control FSM and datapath registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         op_q  <= '0;
         rd_q  <= '0;
         opnd  <= '0;
         acc   <= '0;
         neg   <= 1'b0;
         cnt   <= '0;
      end else if (flush_i) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start_i) begin
                  op_q  <= op_i;
                  rd_q  <= rd_waddr;
                  cnt   <= '0;
                  neg   <= neg_res;
                  state <= CALC;
                  if (is_div) begin
                     opnd <= mag2;
                     acc  <= {{XLEN{1'b0}}, mag1};
                     if (div_zero) begin
                        // Quotient all-ones, remainder is the raw dividend
                        acc   <= {rs1_rdata, {XLEN{1'b1}}};
                        neg   <= 1'b0;
                        state <= DONE;
                     end else if (div_ovf) begin
                        // Most-negative / -1: quotient wraps to the dividend, remainder 0
                        acc   <= {{XLEN{1'b0}}, rs1_rdata};
                        neg   <= 1'b0;
                        state <= DONE;
                     end
                  end else begin
                     opnd <= mag1;
`ifdef MULDIV_FAST_MUL_EN
                     acc   <= {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
                     state <= DONE;
`else
                     acc   <= {{XLEN{1'b0}}, mag2};
`endif
                  end
               end else begin
                  state <= IDLE;
               end
            end
            CALC: begin
               acc <= op_q[2] ? div_next : mul_next;
               cnt <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exmuldiv.sv
// tb_exmuldiv: directed vectors for exmuldiv with a queue scoreboard and a decoupled output monitor.
// Latency: expected valid_o cycle is pushed with each issued op and compared on the result beat.
// Backpressure: none; the bench also watches hold_o around issue, special cases, flush and reset.
module tb_exmuldiv;

   logic        clk;
   logic        rst;
   logic        start_i;
   logic [2:0]  op_i;
   logic [31:0] rs1_rdata;
   logic [31:0] rs2_rdata;
   logic [4:0]  rd_waddr;
   logic        flush_i;
   logic        hold_o;
   logic        valid_o;
   logic [4:0]  rd_waddr_o;
   logic [31:0] rd_wdata_o;

   exmuldiv #(.XLEN(32), .RADDR_W(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .op_i       (op_i),
      .rs1_rdata  (rs1_rdata),
      .rs2_rdata  (rs2_rdata),
      .rd_waddr   (rd_waddr),
      .flush_i    (flush_i),
      .hold_o     (hold_o),
      .valid_o    (valid_o),
      .rd_waddr_o (rd_waddr_o),
      .rd_wdata_o (rd_wdata_o)
   );

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
   localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

   typedef struct {
      int          cyc;
      logic [4:0]  rd;
      logic [31:0] dat;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   nvalid = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pops an expectation each time the DUT presents a write-back beat
   task automatic monitor();
      forever begin
         @(negedge clk);
         if (valid_o) begin
            nvalid++;
            chk(exp_q.size() != 0, "valid_expected", 64'(valid_o), 64'(0));
            if (exp_q.size() != 0) begin
               exp_t e;
               e = exp_q.pop_front();
               chk(rd_wdata_o == e.dat, {e.name, "_data"}, 64'(rd_wdata_o), 64'(e.dat));
               chk(rd_waddr_o == e.rd, {e.name, "_rd"}, 64'(rd_waddr_o), 64'(e.rd));
               chk(cyc == e.cyc, {e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
            end
         end
      end
   endtask

   // Drive one issue cycle; expectation lands at (issue cycle + lat)
   task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] expv, input int lat,
                       input bit push, input string nm);
      exp_t e;
      start_i   = 1'b1;
      op_i      = op;
      rs1_rdata = a;
      rs2_rdata = b;
      rd_waddr  = rd;
      #1;
      chk(hold_o == 1'b1, {nm, "_hold_issue"}, 64'(hold_o), 64'(1));
      if (push) begin
         e.cyc  = cyc + lat;
         e.rd   = rd;
         e.dat  = expv;
         e.name = nm;
         exp_q.push_back(e);
      end
      tick();
      start_i   = 1'b0;
      rs1_rdata = $urandom;
      rs2_rdata = $urandom;
      rd_waddr  = 5'($urandom_range(0, 31));
      op_i      = 3'($urandom_range(0, 7));
      if (lat == 1) begin
         #1;
         chk(hold_o == 1'b0, {nm, "_hold_after"}, 64'(hold_o), 64'(0));
      end
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      chk(exp_q.size() == 0, {nm, "_drain_timeout"}, 64'(exp_q.size()), 64'(0));
      tick();
   endtask

   initial begin
      int v0;
      int gaps;
      rst       = 1'b0;
      start_i   = 1'b0;
      op_i      = 3'd0;
      rs1_rdata = '0;
      rs2_rdata = '0;
      rd_waddr  = '0;
      flush_i   = 1'b0;
      fork
         monitor();
         begin
            #1_000_000;
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1, "watchdog");
         end
      join_none

      repeat (3) tick();
      rst = 1'b1;
      tick();
      chk(valid_o == 1'b0, "reset_valid", 64'(valid_o), 64'(0));
      chk(hold_o == 1'b0, "reset_hold", 64'(hold_o), 64'(0));
      chk(rd_waddr_o == 5'd0, "reset_rd", 64'(rd_waddr_o), 64'(0));
      chk(rd_wdata_o == 32'd0, "reset_data", 64'(rd_wdata_o), 64'(0));

      // Iterative divide / remainder, signed
      send(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, DIV_LAT, 1'b1, "div_m7_2");
      drain("div_m7_2");
      send(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, DIV_LAT, 1'b1, "rem_m7_2");
      drain("rem_m7_2");
      send(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 5'd12, 32'h0FFF_FFFF, DIV_LAT, 1'b1, "divu_big");
      drain("divu_big");

      // Multiplies
      send(OP_MULH, 32'h8000_0000, 32'h8000_0000, 5'd7, 32'h4000_0000, MUL_LAT, 1'b1, "mulh_min");
      drain("mulh_min");
      send(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFE, MUL_LAT, 1'b1, "mulhu_ones");
      drain("mulhu_ones");
      send(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'h0000_0001, MUL_LAT, 1'b1, "mul_ones");
      drain("mul_ones");
      send(OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd10, 32'hFFFF_FFFF, MUL_LAT, 1'b1, "mulhsu_m1_2");
      drain("mulhsu_m1_2");
      send(OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd11, 32'hFFFF_FFEB, MUL_LAT, 1'b1, "mul_7_m3");
      drain("mul_7_m3");

      // Special cases complete one cycle after issue
      send(OP_DIVU, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, 1, 1'b1, "divu_by0");
      drain("divu_by0");
      send(OP_REMU, 32'd5, 32'd0, 5'd14, 32'd5, 1, 1'b1, "remu_by0");
      drain("remu_by0");
      send(OP_REM, 32'hFFFF_FFF9, 32'd0, 5'd15, 32'hFFFF_FFF9, 1, 1'b1, "rem_m7_by0");
      drain("rem_m7_by0");
      send(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1, 1'b1, "div_ovf");
      drain("div_ovf");
      send(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0000_0000, 1, 1'b1, "rem_ovf");
      drain("rem_ovf");

      // Flush mid-operation: result discarded, stall released next cycle
      v0 = nvalid;
      send(OP_DIVU, 32'd100, 32'd7, 5'd18, 32'd0, DIV_LAT, 1'b0, "flush_op");
      repeat (9) tick();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      chk(hold_o == 1'b0, "flush_hold", 64'(hold_o), 64'(0));
      repeat (40) tick();
      chk(nvalid == v0, "flush_no_valid", 64'(nvalid - v0), 64'(0));

      // Reset mid-operation: same response as flush
      v0 = nvalid;
      send(OP_DIVU, 32'd100, 32'd7, 5'd19, 32'd0, DIV_LAT, 1'b0, "reset_op");
      repeat (9) tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk(hold_o == 1'b0, "midreset_hold", 64'(hold_o), 64'(0));
      repeat (40) tick();
      chk(nvalid == v0, "midreset_no_valid", 64'(nvalid - v0), 64'(0));

      // Back-to-back: second op issued in the first op's DONE cycle, hold never drops
      gaps = 0;
      send(OP_DIVU, 32'd100, 32'd7, 5'd20, 32'd14, DIV_LAT, 1'b1, "b2b_divu");
      for (int i = 0; i < 32; i++) begin
         if (!hold_o) gaps++;
         tick();
      end
      send(OP_REMU, 32'd100, 32'd7, 5'd21, 32'd2, DIV_LAT, 1'b1, "b2b_remu");
      for (int i = 0; i < 32; i++) begin
         if (!hold_o) gaps++;
         tick();
      end
      chk(gaps == 0, "b2b_hold_gaps", 64'(gaps), 64'(0));
      chk(hold_o == 1'b0, "b2b_hold_done", 64'(hold_o), 64'(0));
      drain("b2b");

      // Flush and start together: flush wins, nothing accepted
      v0 = nvalid;
      start_i   = 1'b1;
      flush_i   = 1'b1;
      op_i      = OP_DIVU;
      rs1_rdata = 32'd100;
      rs2_rdata = 32'd7;
      rd_waddr  = 5'd22;
      #1;
      chk(hold_o == 1'b0, "flush_start_hold", 64'(hold_o), 64'(0));
      tick();
      start_i = 1'b0;
      flush_i = 1'b0;
      #1;
      chk(hold_o == 1'b0, "flush_start_hold_next", 64'(hold_o), 64'(0));
      repeat (40) tick();
      chk(nvalid == v0, "flush_start_no_valid", 64'(nvalid - v0), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
